// File: rtl/univ_reg_if.sv
// Bus bundle for univ_reg: enable, mode and data inputs plus register outputs.
interface univ_reg_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic [2:0]       M;
  logic [WIDTH-1:0] D;
  logic             SL;
  logic             SR;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             Z;

  modport master (
    output E, M, D, SL, SR,
    input  Q, SO, Z
  );

  modport slave (
    input  E, M, D, SL, SR,
    output Q, SO, Z
  );
endinterface

// File: rtl/univ_reg.sv
// Universal register: load, shift, rotate and up/down count.
// All state changes happen on the falling edge of C. Rn is a synchronous,
// active-low reset and is only looked at on that edge.
module univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic     C,
  input  logic     Rn,
  univ_reg_if.slave bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_UP   = 3'b110;
  localparam logic [2:0] M_DN   = 3'b111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;

  // Next value of Q and SO for the enabled mode; E low holds both.
  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    if (bus.E) begin
      case (bus.M)
        M_HOLD: begin
          q_d  = q_q;
          so_d = 1'b0;
        end
        M_LOAD: begin
          q_d  = bus.D;
          so_d = 1'b0;
        end
        M_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.SL};
          so_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d  = {bus.SR, q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        M_ROL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          so_d = q_q[WIDTH-1];
        end
        M_ROR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        M_UP: begin
          // Carry out only on the all-ones to zero wrap.
          q_d  = q_q + ONE;
          so_d = &q_q;
        end
        M_DN: begin
          // Borrow out only on the zero to all-ones wrap.
          q_d  = q_q - ONE;
          so_d = ~|q_q;
        end
        default: begin
          q_d  = q_q;
          so_d = so_q;
        end
      endcase
    end
  end

  // Falling-edge state register; reset overrides enable and mode.
  always_ff @(negedge C) begin
    if (!Rn) begin
      q_q  <= RESET_VAL;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign bus.Q  = q_q;
  assign bus.SO = so_q;
  assign bus.Z  = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg: directed scenarios followed by random steps, all
// checked against an arithmetic model of the register.
module tb_univ_reg;
  localparam int W   = 8;
  localparam int MOD = 2 ** W;
  localparam int TOP = 2 ** (W - 1);

  logic clk = 1'b1;
  logic rn;

  univ_reg_if #(.WIDTH(W)) u_if ();

  univ_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .C  (clk),
    .Rn (rn),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int mq  = 0;
  int mso = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Q"},  32'(u_if.Q),  32'(mq));
    check({tag, ".SO"}, 32'(u_if.SO), 32'(mso));
    check({tag, ".Z"},  32'(u_if.Z),  (mq == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic model_edge(input bit r, input bit e, input int m, input int d,
                            input int sl, input int sr);
    int old;
    old = mq;
    if (!r) begin
      mq  = 0;
      mso = 0;
    end else if (e) begin
      case (m)
        0: mso = 0;
        1: begin mq = d % MOD; mso = 0; end
        2: begin mq = (old * 2 + sl) % MOD;          mso = old / TOP; end
        3: begin mq = old / 2 + sr * TOP;            mso = old % 2;   end
        4: begin mq = (old * 2) % MOD + old / TOP;   mso = old / TOP; end
        5: begin mq = old / 2 + (old % 2) * TOP;     mso = old % 2;   end
        6: begin mq = (old + 1) % MOD;               mso = (old == MOD - 1) ? 1 : 0; end
        default: begin mq = (old + MOD - 1) % MOD;   mso = (old == 0) ? 1 : 0; end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit e, input int m, input int d,
                      input int sl, input int sr, input string tag);
    rn      = r;
    u_if.E  = e;
    u_if.M  = 3'(m);
    u_if.D  = 8'(d);
    u_if.SL = sl[0];
    u_if.SR = sr[0];
    model_edge(r, e, m, d, sl, sr);
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rn      = 1'b0;
    u_if.E  = 1'b0;
    u_if.M  = 3'b000;
    u_if.D  = '0;
    u_if.SL = 1'b0;
    u_if.SR = 1'b0;

    step(0, 0, 0, 0, 0, 0, "reset");

    // Reset while counting
    step(1, 1, 1, 8'h05, 0, 0, "load05");
    step(0, 1, 6, 0, 0, 0, "rst_mid_count");
    step(1, 1, 6, 0, 0, 0, "count_resume1");
    step(1, 1, 6, 0, 0, 0, "count_resume2");

    // Load, then enable low
    step(1, 1, 1, 8'hA5, 0, 0, "loadA5");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h3C, 0, 0, "en_low_hold");

    // Shift left
    step(1, 1, 1, 8'h81, 0, 0, "load81_a");
    step(1, 1, 2, 0, 1, 0, "shl1");
    step(1, 1, 2, 0, 1, 0, "shl2");

    // Shift right
    step(1, 1, 1, 8'h81, 0, 0, "load81_b");
    step(1, 1, 3, 0, 0, 0, "shr");

    // Rotate
    step(1, 1, 1, 8'h81, 0, 0, "load81_c");
    step(1, 1, 4, 0, 0, 0, "rol");
    step(1, 1, 5, 0, 0, 0, "ror");

    // Count wrap up and down
    step(1, 1, 1, 8'hFE, 0, 0, "loadFE");
    step(1, 1, 6, 0, 0, 0, "up_FF");
    step(1, 1, 6, 0, 0, 0, "up_wrap");
    step(1, 1, 6, 0, 0, 0, "up_01");
    step(1, 1, 1, 8'h01, 0, 0, "load01");
    step(1, 1, 7, 0, 0, 0, "dn_00");
    step(1, 1, 7, 0, 0, 0, "dn_wrap");

    // Inputs toggled only around a rising edge must not change state
    u_if.E = 1'b0;
    #3;
    u_if.E = 1'b1;
    u_if.M = 3'b001;
    u_if.D = 8'h55;
    @(posedge clk);
    #1;
    check_all("posedge_toggle");
    u_if.E = 1'b0;
    u_if.M = 3'b000;
    u_if.D = 8'h00;
    @(negedge clk);
    #1;
    check_all("after_posedge_toggle");

    // Reset pulse strictly between falling edges must be ignored
    #1;
    rn = 1'b0;
    #2;
    rn = 1'b1;
    check_all("rn_pulse_mid");
    @(posedge clk);
    #1;
    rn = 1'b0;
    #1;
    rn = 1'b1;
    @(negedge clk);
    #1;
    check_all("rn_pulse_after");

    // Random operation mix
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
